decodificador_param: RTL and testbench
======================================

Name: decodificador_param

Overview:
- Parametrised, pipelined successor to the fixed 4-to-6 complement decoder.
- Converts an IN_W-bit code into an OUT_W-bit word in one of four run-time modes: complement, pass, one-hot, thermometer.
- Uses valid/ready handshakes, flags codes that do not fit, and counts those errors.
- Sits between a code source (counter, keypad, ALU field) and display/drive logic in the course FPGA designs.

Parameters:
- IN_W, 4, input code width (1..8).
- OUT_W, 6, output word width (1..16).
- STAGES, 2, pipeline register stages (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept this cycle.
- in_data  input  IN_W  code A.
- in_mode  input  2  0=complement, 1=pass, 2=one-hot, 3=thermometer.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  decoded word.
- out_err  output  1  code did not fit OUT_W for this word.
- err_cnt  output  8  saturating count of delivered words with out_err=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all stage valids, out_valid, out_data, out_err and err_cnt go to 0.
  - pipeline contents are flushed; in-flight words are lost.
  - in_ready=1 on the first cycle after reset is released.
- Input accept: when in_valid && in_ready. in_mode is captured with in_data; a mode change affects only later accepted words.
- Mapping, with M = 2^IN_W - 1:
  - mode 0: V = M - A.
  - mode 1: V = A.
  - Modes 0/1: out_data = V[OUT_W-1:0]; out_err = 1 if V >= 2^OUT_W.
  - mode 2: bit A set, all others 0, if A < OUT_W; else all ones and out_err=1.
  - mode 3: lowest A bits set (A=0 gives 0) if A <= OUT_W; else all ones and out_err=1.
- Decode is combinational into stage 0; stages 1..STAGES-1 are plain registers.
- Pipeline is elastic:
  - stage k loads when it is empty or its contents move on the same cycle.
  - last stage drives out_valid/out_data/out_err.
  - in_ready = !v0 || stage 0 advancing. in_ready is combinational from out_ready through the chain; this path is permitted.
- Latency: a word accepted at edge n shows out_valid=1 after edge n+STAGES-1 (STAGES=1 gives the next cycle).
- Throughput: one word per cycle with out_ready=1; no bubbles.
- Backpressure: with out_ready=0, out_valid/out_data/out_err hold stable. Up to STAGES words are buffered; then in_ready=0.
- Ordering is strictly FIFO.
- err_cnt increments on each output handshake (out_valid && out_ready) with out_err=1. It saturates at 255 and never wraps.
- Simultaneous accept and deliver in the same cycle is legal at full occupancy; occupancy stays unchanged.

Optional Feature:
- Macro: DECODIFICADOR_PARITY_EN.
- Defined:
  - extra port out_par (output, 1) = XOR of all out_data bits, registered through the pipeline alongside out_data.
  - out_par is 0 at reset and held under backpressure like out_data.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (IN_W=4, OUT_W=6, STAGES=2):
- Reset, mode 0, A=0 then A=15 -> out_data=6'd15 then 6'd0, first out_valid one cycle after accept, out_err=0.
- Mode 0, A=0..15 back-to-back, out_ready=1 -> 16 consecutive outputs 15..0, in_ready constantly 1, no gaps.
- Mode 2, A=5 then A=6 -> 6'b100000 (err=0), then 6'b111111 (err=1); err_cnt=1 after second handshake.
- Mode 3, A=3 then A=9 -> 6'b000111, then 6'b111111 with err=1; A=6 -> 6'b111111 with err=0.
- out_ready=0, offer A=1,2,3 in mode 1 -> exactly 2 accepted, in_ready=0, out_data=1 stable; out_ready=1 -> 1,2,3 delivered in order.
- 300 error words, then rst_n=0 mid-stream -> err_cnt holds 255 before reset; after the reset edge out_valid=0 and err_cnt=0.

Source files
------------

// File: rtl/decodificador_param_if.sv
// Handshake bundle for decodificador_param: code/mode in, decoded word out.
// Define DECODIFICADOR_PARITY_EN to carry the out_par bit as well.
interface decodificador_param_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
    logic [7:0]       err_cnt;
`ifdef DECODIFICADOR_PARITY_EN
    logic             out_par;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_cnt, out_par
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err, err_cnt, out_par
    );
`else
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_cnt
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err, err_cnt
    );
`endif
endinterface

// File: rtl/decodificador_param.sv
// Parametrised code decoder (complement/pass/one-hot/thermometer) feeding an
// elastic STAGES-deep pipeline. Optional out_par via DECODIFICADOR_PARITY_EN.
module decodificador_param #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 6,
    parameter int STAGES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    decodificador_param_if.slave bus
);
    localparam int MAX_CODE = (1 << IN_W) - 1;

    logic [31:0]      a_ext;
    logic [31:0]      v_ext;
    logic [OUT_W-1:0] dec_data;
    logic             dec_err;

    always_comb begin
        a_ext    = 32'(bus.in_data);
        v_ext    = '0;
        dec_data = '0;
        dec_err  = 1'b0;
        unique case (bus.in_mode)
            2'd0, 2'd1: begin
                v_ext    = (bus.in_mode == 2'd0) ? (32'(MAX_CODE) - a_ext) : a_ext;
                dec_data = v_ext[OUT_W-1:0];
                dec_err  = (v_ext >> OUT_W) != 32'd0;
            end
            2'd2: begin
                if (a_ext < 32'(OUT_W)) begin
                    dec_data = OUT_W'(1) << a_ext;
                end else begin
                    dec_data = '1;
                    dec_err  = 1'b1;
                end
            end
            default: begin
                // Shifting all-ones by exactly OUT_W leaves zero, so A == OUT_W yields all ones.
                if (a_ext <= 32'(OUT_W)) begin
                    dec_data = ~({OUT_W{1'b1}} << a_ext);
                end else begin
                    dec_data = '1;
                    dec_err  = 1'b1;
                end
            end
        endcase
    end

    logic [STAGES-1:0] v_vec;
    logic [STAGES-1:0] e_vec;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_e;
    logic [OUT_W-1:0]  d_arr [STAGES];
    logic [OUT_W-1:0]  src_d [STAGES];
`ifdef DECODIFICADOR_PARITY_EN
    logic [STAGES-1:0] p_vec;
    logic [STAGES-1:0] src_p;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             v_reg;
            logic [OUT_W-1:0] d_reg;
            logic             e_reg;

            // A stage can load iff it or some stage downstream has a hole, or the tail drains.
            assign load[gi] = bus.out_ready | ~(&v_vec[STAGES-1:gi]);

            if (gi == 0) begin : g_head
                assign src_v[gi] = bus.in_valid;
                assign src_d[gi] = dec_data;
                assign src_e[gi] = dec_err;
`ifdef DECODIFICADOR_PARITY_EN
                assign src_p[gi] = ^dec_data;
`endif
            end else begin : g_body
                assign src_v[gi] = v_vec[gi-1];
                assign src_d[gi] = d_arr[gi-1];
                assign src_e[gi] = e_vec[gi-1];
`ifdef DECODIFICADOR_PARITY_EN
                assign src_p[gi] = p_vec[gi-1];
`endif
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                    e_reg <= 1'b0;
                end else if (load[gi]) begin
                    v_reg <= src_v[gi];
                    d_reg <= src_d[gi];
                    e_reg <= src_e[gi];
                end
            end

            assign v_vec[gi] = v_reg;
            assign d_arr[gi] = d_reg;
            assign e_vec[gi] = e_reg;

`ifdef DECODIFICADOR_PARITY_EN
            logic p_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    p_reg <= 1'b0;
                end else if (load[gi]) begin
                    p_reg <= src_p[gi];
                end
            end
            assign p_vec[gi] = p_reg;
`endif
        end
    endgenerate

    logic [7:0] err_cnt_reg;
    logic [7:0] err_cnt_next;
    logic       deliver;

    assign deliver = v_vec[STAGES-1] & bus.out_ready;

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (deliver && e_vec[STAGES-1] && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_reg <= 8'd0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v_vec[STAGES-1];
    assign bus.out_data  = d_arr[STAGES-1];
    assign bus.out_err   = e_vec[STAGES-1];
    assign bus.err_cnt   = err_cnt_reg;
`ifdef DECODIFICADOR_PARITY_EN
    assign bus.out_par   = p_vec[STAGES-1];
`endif
endmodule

// File: tb/tb_decodificador_param.sv
// Self-checking bench for decodificador_param (IN_W=4, OUT_W=6, STAGES=2):
// directed table, back-to-back, backpressure, random and saturation/reset sequences.
module tb_decodificador_param;
    localparam int IN_W   = 4;
    localparam int OUT_W  = 6;
    localparam int STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decodificador_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    decodificador_param #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             err;
        logic [OUT_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  a;
        logic [OUT_W-1:0] d;
        logic             e;
    } vec_t;

    exp_t             exp_q [$];
    logic [OUT_W-1:0] dlv_q [$];
    exp_t             mon_e;
    int               err_model = 0;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    logic             prev_err = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference decode straight from the mapping rules, using integer arithmetic.
    function automatic exp_t ref_dec(input int mode, input int a);
        exp_t r;
        int   full;
        int   v;
        full  = (1 << OUT_W) - 1;
        r.err = 1'b0;
        case (mode)
            0, 1: begin
                v      = (mode == 0) ? ((1 << IN_W) - 1 - a) : a;
                r.data = OUT_W'(v % (1 << OUT_W));
                r.err  = (v > full);
            end
            2: begin
                if (a < OUT_W) r.data = OUT_W'(1 << a);
                else begin r.data = OUT_W'(full); r.err = 1'b1; end
            end
            default: begin
                if (a <= OUT_W) r.data = OUT_W'((1 << a) - 1);
                else begin r.data = OUT_W'(full); r.err = 1'b1; end
            end
        endcase
        return r;
    endfunction

    // Scoreboard: handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_model  = 0;
            prev_stall = 1'b0;
        end else begin
            chk("err_cnt_track", bus.err_cnt, err_model);
            chk("in_ready_occ", bus.in_ready, (exp_q.size() < STAGES) || bus.out_ready);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_err", bus.out_err, prev_err);
            end
`ifdef DECODIFICADOR_PARITY_EN
            if (bus.out_valid) chk("parity", bus.out_par, ^bus.out_data);
`endif
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data %0d, expected no word", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_data", bus.out_data, mon_e.data);
                    chk("sb_err", bus.out_err, mon_e.err);
                end
                dlv_q.push_back(bus.out_data);
                if (bus.out_err && err_model < 255) err_model++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_dec(int'(bus.in_mode), int'(bus.in_data)));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_err   = bus.out_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl [10];

    initial begin
        int a;
        int acc;
        int exp_cnt;

        tbl[0] = '{2'd0, 4'd0,  6'd15,       1'b0};
        tbl[1] = '{2'd0, 4'd15, 6'd0,        1'b0};
        tbl[2] = '{2'd2, 4'd5,  6'b100000,   1'b0};
        tbl[3] = '{2'd2, 4'd6,  6'b111111,   1'b1};
        tbl[4] = '{2'd3, 4'd3,  6'b000111,   1'b0};
        tbl[5] = '{2'd3, 4'd9,  6'b111111,   1'b1};
        tbl[6] = '{2'd3, 4'd6,  6'b111111,   1'b0};
        tbl[7] = '{2'd1, 4'd9,  6'd9,        1'b0};
        tbl[8] = '{2'd2, 4'd0,  6'b000001,   1'b0};
        tbl[9] = '{2'd3, 4'd0,  6'b000000,   1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Directed table: one word at a time, latency and value checked.
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = tbl[i].mode;
            bus.in_data  = tbl[i].a;
            @(negedge clk);
            chk("tbl_in_ready", bus.in_ready, 1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_latency_early", bus.out_valid, 0);
            @(negedge clk);
            chk("tbl_out_valid", bus.out_valid, 1);
            chk("tbl_out_data", bus.out_data, tbl[i].d);
            chk("tbl_out_err", bus.out_err, tbl[i].e);
            if (tbl[i].e) exp_cnt++;
            @(negedge clk);
            chk("tbl_err_cnt", bus.err_cnt, exp_cnt);
            chk("tbl_drained", bus.out_valid, 0);
        end

        // Back-to-back complement 0..15 with no gaps.
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            bus.in_valid = (i < 16);
            bus.in_mode  = 2'd0;
            bus.in_data  = 4'(i);
            @(negedge clk);
            if (i < 16) chk("b2b_in_ready", bus.in_ready, 1);
            if (i >= 2) begin
                chk("b2b_out_valid", bus.out_valid, 1);
                chk("b2b_out_data", bus.out_data, 15 - (i - 2));
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Backpressure: two words buffered, third waits, then FIFO drain.
        dlv_q.delete();
        bus.out_ready = 1'b0;
        a   = 1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = 2'd1;
            bus.in_data  = 4'(a);
            @(negedge clk);
            if (bus.in_ready) begin acc++; a++; end
            if (c >= 2) begin
                chk("bp_stall_valid", bus.out_valid, 1);
                chk("bp_stall_data", bus.out_data, 1);
            end
        end
        chk("bp_accepted", acc, STAGES);
        chk("bp_in_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && a <= 3; c++) begin
            @(negedge clk);
            if (bus.in_ready) a++;
            @(posedge clk); #1;
            if (a > 3) bus.in_valid = 1'b0;
            else bus.in_data = 4'(a);
        end
        bus.in_valid = 1'b0;
        chk("bp_third_accepted", a, 4);
        repeat (4) @(negedge clk);
        chk("bp_delivered", dlv_q.size(), 3);
        if (dlv_q.size() >= 3)
            for (int i = 0; i < 3; i++) chk("bp_order", dlv_q[i], i + 1);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_mode   = 2'($urandom_range(0, 3));
            bus.in_data   = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rnd_all_delivered", exp_q.size(), 0);

        // Saturation: 300 error words, then reset mid-stream.
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = 2'd2;
            bus.in_data  = 4'd15;
        end
        @(negedge clk);
        chk("sat_err_cnt", bus.err_cnt, 255);
        chk("sat_stream_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_err_cnt", bus.err_cnt, 0);
        chk("mid_rst_out_err", bus.out_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
